// File: rtl/axi_lite_test2_regbank_slave_if.sv
// ---------------------------------------------------------------------------
// axi_lite_test2_regbank_slave_if
// Purpose : AXI4-Lite bus bundle between the lite master BFM and the
//           register-bank slave.
// Signals : write address (AW), write data (W), write response (B),
//           read address (AR) and read data (R) channels.
//           The clock and reset are not carried here; they remain plain
//           ports on the modules that use this bundle.
// Handshake rule (applies to every channel): a transfer happens on a rising
// clock edge where VALID and READY are both high.  The source holds VALID
// and its payload stable until that edge.  READY may be high without VALID.
// Modports: master (BFM side), slave (register bank side).
// ---------------------------------------------------------------------------
interface axi_lite_test2_regbank_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_test2_regbank_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_test2_regbank_slave
// Purpose : AXI4-Lite slave holding four 32-bit read/write control
//           registers at byte offsets 0x00/0x04/0x08/0x0C.  Offsets
//           0x10-0x1C are unmapped and answer SLVERR.  The register
//           contents are also exported as a flat bus.
// Ports   : S_AXI_ACLK    - clock, rising edge
//           S_AXI_ARESETN - asynchronous active-low reset
//           s_axi         - AXI4-Lite bus (slave modport)
//           reg_out       - {reg3, reg2, reg1, reg0}
// Notes   : AW and W are accepted independently and held until both are
//           present; the register write and BVALID happen one edge later.
//           All READY outputs are flops loaded with their next-cycle value,
//           so they read 0 while reset is asserted and still obey
//           AWREADY = !aw_held && !BVALID, WREADY = !w_held && !BVALID,
//           ARREADY = !RVALID once running.
// ---------------------------------------------------------------------------
module axi_lite_test2_regbank_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  axi_lite_test2_regbank_slave_if.slave   s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register bank
  logic [31:0] r_regs [4];

  // Write channel state
  logic        r_aw_held;
  logic [4:2]  r_awaddr;
  logic        r_w_held;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;

  // Read channel state
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  // Handshake and next-state wires
  logic w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire;
  logic w_commit;
  logic w_aw_held_nxt, w_w_held_nxt, w_bvalid_nxt, w_rvalid_nxt;

  // PROT and the byte-offset address bits carry no meaning here.
  logic w_unused;
  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                      s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  always_comb begin
    w_aw_fire = s_axi.S_AXI_AWVALID && r_awready;
    w_w_fire  = s_axi.S_AXI_WVALID  && r_wready;
    w_b_fire  = r_bvalid && s_axi.S_AXI_BREADY;
    w_ar_fire = s_axi.S_AXI_ARVALID && r_arready;
    w_r_fire  = r_rvalid && s_axi.S_AXI_RREADY;

    // Both phases held and no response outstanding: perform the write now.
    // BVALID rising on this same edge blocks a second commit.
    w_commit = r_aw_held && r_w_held && !r_bvalid;

    // READY is low while BVALID is high, so a new AW/W cannot fire on the
    // B handshake edge; the held flags simply clear there.
    w_aw_held_nxt = w_b_fire ? 1'b0 : (r_aw_held || w_aw_fire);
    w_w_held_nxt  = w_b_fire ? 1'b0 : (r_w_held  || w_w_fire);
    w_bvalid_nxt  = w_commit ? 1'b1 : (w_b_fire ? 1'b0 : r_bvalid);
    w_rvalid_nxt  = w_ar_fire ? 1'b1 : (w_r_fire ? 1'b0 : r_rvalid);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_aw_held <= 1'b0;
      r_awaddr  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_awready <= !w_aw_held_nxt && !w_bvalid_nxt;
      r_wready  <= !w_w_held_nxt  && !w_bvalid_nxt;
      r_arready <= !w_rvalid_nxt;

      if (w_aw_fire) r_awaddr <= s_axi.S_AXI_AWADDR[4:2];
      if (w_w_fire) begin
        r_wdata <= s_axi.S_AXI_WDATA;
        r_wstrb <= s_axi.S_AXI_WSTRB;
      end

      if (w_commit) begin
        r_bresp <= r_awaddr[4] ? RESP_SLVERR : RESP_OKAY;
        if (!r_awaddr[4]) begin
          for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b]) r_regs[r_awaddr[3:2]][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end

      // Non-blocking read of r_regs: a write landing on this same edge is
      // not visible, so the read returns the pre-write value.
      if (w_ar_fire) begin
        if (s_axi.S_AXI_ARADDR[4]) begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end else begin
          r_rdata <= r_regs[s_axi.S_AXI_ARADDR[3:2]];
          r_rresp <= RESP_OKAY;
        end
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;

  assign reg_out = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};

endmodule
